k10_alu_arbiter: RTL and testbench
==================================

Name: k10_alu_arbiter

Overview:
Shares one k10_alu instance among NUM_REQ requesters, e.g. the main execute path and a CSR or address-generation helper. Each requester uses a valid/ready request handshake and a valid/ready response handshake. Requests are granted round-robin. The ALU result is registered in a single output stage, so latency is one cycle and throughput is one operation per cycle when responses drain immediately.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4; elaboration error outside this range.
ID_W, $clog2(NUM_REQ), derived width of the requester index; not overridable.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst_n  input  1  reset, asynchronous and active-low.
i_flush  input  1  synchronous flush; drops the pending response and blocks new grants this cycle.
i_req_valid  input  NUM_REQ  per-requester request valid.
o_req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
i_req_op  input  NUM_REQ x alu_op_e  per-requester ALU operation.
i_req_a  input  NUM_REQ x 32  per-requester operand A.
i_req_b  input  NUM_REQ x 32  per-requester operand B.
o_rsp_valid  output  NUM_REQ  per-requester response valid; one-hot or zero.
i_rsp_ready  input  NUM_REQ  per-requester response accept.
o_rsp_result  output  32  shared result bus; meaningful only for the requester whose o_rsp_valid is high.
o_idle  output  1  high when no response is pending.

Behaviour:
- State:
  - rsp_full (1 bit)
  - rsp_id (ID_W bits)
  - rsp_result (32 bits)
  - rr_ptr (ID_W bits): the highest-priority requester index.
- Reset values: rsp_full=0, rsp_id=0, rsp_result=0, rr_ptr=0.
  - Resulting outputs: o_rsp_valid=0, o_rsp_result=0, o_idle=1, o_req_ready=0.
- rsp_fire = rsp_full & i_rsp_ready[rsp_id].
- can_accept = !i_flush & (!rsp_full | rsp_fire).
- Grant:
  - g is the first index with i_req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - o_req_ready[g] = can_accept. All other ready bits are 0. No grant when no request is valid.
  - o_req_ready may depend combinationally on i_req_valid and i_rsp_ready.
  - Requesters must not make i_req_valid depend on o_req_ready.
- Request fire (i_req_valid[g] & o_req_ready[g]):
  - rsp_result <= k10_alu(i_req_op[g], i_req_a[g], i_req_b[g]).
  - rsp_id <= g; rsp_full <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Response fire without a simultaneous request fire: rsp_full <= 0.
- Response fire and request fire in the same cycle: the new result replaces the old one and rsp_full stays 1. This gives back-to-back throughput of 1/cycle.
- o_rsp_valid[r] = rsp_full & (rsp_id==r). o_rsp_result = rsp_result.
- o_idle = !rsp_full.
- Stall: while the response is valid and not ready, rsp_result and rsp_id stay stable, and no request is accepted.
- Request side: a requester holding valid keeps op, a and b stable until accepted. The arbiter does not check this.
- rr_ptr changes only on request fire.
- Starvation bound: a continuously-valid requester is granted within NUM_REQ accepts.
- Flush:
  - rsp_full <= 0 next edge and all ready bits are 0 in the flush cycle.
  - rr_ptr, rsp_id and rsp_result are held.
  - A response that is ready in the flush cycle still counts as delivered (rsp_fire is evaluated normally).
- Reset asserted mid-operation: all state clears immediately (asynchronously); any pending response is lost.
- Operation encoding: alu_op_e values with no defined operation produce result 0, matching the ALU default.

Decomposition:
- komandara_k10_pkg:
  - alu_op_e (existing).
  - New constant K10_ALU_ARB_MAX_REQ = 4.
- Sub-module k10_rr_arbiter (combinational), parameterised by NUM_REQ:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and grant index.
- k10_alu is instantiated once, fed by the grant mux.

Test Plan:
- Reset/idle: hold i_rst_n low, then release with no requests -> o_rsp_valid=0, o_req_ready=0, o_idle=1, o_rsp_result=0.
- Single request: req0 ALU_ADD a=5 b=7, rsp_ready high -> ready0 in cycle 0; rsp_valid[0]=1 and result=12 in cycle 1; o_idle back to 1 in cycle 2.
- Contention round-robin: req0 SUB 10-3 and req1 SRA 0x80000000>>>4, both held valid, rsp_ready high -> grants in order 0,1,0,1. Results 0x00000007, 0xF8000000, 0x00000007, 0xF8000000 on consecutive cycles.
- Backpressure: response to req1 pending with rsp_ready[1]=0 for 3 cycles while req0 is valid -> ready0=0 and the result stays stable. When rsp_ready[1] rises, req0 is accepted in that same cycle and its response appears the next cycle.
- Flush: response pending and req1 valid, i_flush pulsed for 1 cycle -> ready=0 that cycle, rsp_valid=0 next cycle, rr_ptr unchanged. req1 is accepted the cycle after the flush.
- Async reset mid-stall: rsp_valid high with rsp_ready low, then pulse i_rst_n low between edges -> rsp_valid drops immediately and rr_ptr=0 after release.

Source files
------------

// File: rtl/komandara_k10_pkg.sv
// Shared K10 core types: ALU operation encoding and ALU arbiter limits.
package komandara_k10_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Upper bound on requesters sharing one ALU through k10_alu_arbiter.
    localparam int unsigned K10_ALU_ARB_MAX_REQ = 4;

endpackage

// File: rtl/k10_alu.sv
// K10 integer ALU: purely combinational, unused encodings return zero.
module k10_alu
    import komandara_k10_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    // Select the operation result; shifts use the low five bits of b.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {31'b0, (a_s < b_s)};
            ALU_SLTU: result_o = {31'b0, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = 32'(a_s >>> b_i[4:0]);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/k10_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module k10_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    // Walk the requesters starting from the priority pointer and take the first one.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/k10_alu_arbiter.sv
// Shares one k10_alu among NUM_REQ requesters with round-robin grant and a
// single registered response slot (one-cycle latency, 1 op/cycle when drained).
module k10_alu_arbiter
    import komandara_k10_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_req_ready,
    input  alu_op_e            i_req_op [NUM_REQ],
    input  logic [31:0]        i_req_a  [NUM_REQ],
    input  logic [31:0]        i_req_b  [NUM_REQ],
    output logic [NUM_REQ-1:0] o_rsp_valid,
    input  logic [NUM_REQ-1:0] i_rsp_ready,
    output logic [31:0]        o_rsp_result,
    output logic               o_idle
);

    if (NUM_REQ < 2 || NUM_REQ > K10_ALU_ARB_MAX_REQ) begin : g_bad_num_req
        $error("k10_alu_arbiter: NUM_REQ must be in 2..4");
    end

    logic              rsp_full_q,   rsp_full_d;
    logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]   rr_ptr_q,     rr_ptr_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [31:0]        alu_result;
    logic               rsp_fire;
    logic               can_accept;
    logic               req_fire;

    k10_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i     (i_req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    k10_alu u_alu (
        .op_i     (i_req_op[gnt_idx]),
        .a_i      (i_req_a[gnt_idx]),
        .b_i      (i_req_b[gnt_idx]),
        .result_o (alu_result)
    );

    // A pending response that drains this cycle frees the slot for a new grant.
    assign rsp_fire    = rsp_full_q & i_rsp_ready[rsp_id_q];
    assign can_accept  = !i_flush & (!rsp_full_q | rsp_fire);
    assign o_req_ready = gnt & {NUM_REQ{can_accept}};
    assign req_fire    = |o_req_ready;

    // Next state: a new request overwrites the slot; otherwise drain or flush empties it.
    always_comb begin
        rsp_full_d   = rsp_full_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rr_ptr_d     = rr_ptr_q;
        if (req_fire) begin
            rsp_full_d   = 1'b1;
            rsp_id_d     = gnt_idx;
            rsp_result_d = alu_result;
            rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (rsp_fire || i_flush) begin
            rsp_full_d   = 1'b0;
        end
    end

    // Response slot and priority pointer; reset discards any pending response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_full_q   <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            rsp_full_q   <= rsp_full_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Steer the shared result to its owner only.
    always_comb begin
        o_rsp_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            o_rsp_valid[r] = rsp_full_q && (rsp_id_q == ID_W'(r));
        end
    end

    assign o_rsp_result = rsp_result_q;
    assign o_idle       = !rsp_full_q;

endmodule

// File: tb/tb_k10_alu_arbiter.sv
// Directed bench for k10_alu_arbiter with two requesters.
module tb_k10_alu_arbiter;
    import komandara_k10_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    alu_op_e     req_op [2];
    logic [31:0] req_a  [2];
    logic [31:0] req_b  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    k10_alu_arbiter #(.NUM_REQ(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = ALU_ADD;
            req_a[i]  = '0;
            req_b[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 32'h0);
        check_eq("rst_req_ready", req_ready, 32'h0);
        check_eq("rst_idle",      idle,      32'h1);
        check_eq("rst_result",    rsp_result, 32'h0);

        // Single request: 5 + 7
        tick();
        req_valid = 2'b01; req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
        rsp_ready = 2'b11;
        #1 check_eq("single_ready", req_ready, 32'h1);
        tick(); req_valid = 2'b00;
        #1 check_eq("single_rsp_valid", rsp_valid, 32'h1);
        check_eq("single_result", rsp_result, 32'd12);
        check_eq("single_busy", idle, 32'h0);
        tick();
        #1 check_eq("single_idle", idle, 32'h1);
        check_eq("single_drained", rsp_valid, 32'h0);

        // Lone req1 XOR (moves pointer back to 0)
        req_valid = 2'b10; req_op[1] = ALU_XOR; req_a[1] = 32'hF0F0_F0F0; req_b[1] = 32'hFF00_FF00;
        #1 check_eq("xor_ready", req_ready, 32'h2);
        tick(); req_valid = 2'b00;
        #1 check_eq("xor_rsp_valid", rsp_valid, 32'h2);
        check_eq("xor_result", rsp_result, 32'h0FF0_0FF0);

        // Contention: both valid, expect 0,1,0,1
        req_op[0] = ALU_SUB; req_a[0] = 32'd10;          req_b[0] = 32'd3;
        req_op[1] = ALU_SRA; req_a[1] = 32'h8000_0000;   req_b[1] = 32'd4;
        req_valid = 2'b11;
        #1 check_eq("rr_gnt0", req_ready, 32'h1);
        tick();
        #1 check_eq("rr_rsp0_valid", rsp_valid, 32'h1);
        check_eq("rr_rsp0_result", rsp_result, 32'h0000_0007);
        check_eq("rr_gnt1", req_ready, 32'h2);
        tick();
        #1 check_eq("rr_rsp1_valid", rsp_valid, 32'h2);
        check_eq("rr_rsp1_result", rsp_result, 32'hF800_0000);
        check_eq("rr_gnt2", req_ready, 32'h1);
        tick();
        #1 check_eq("rr_rsp2_valid", rsp_valid, 32'h1);
        check_eq("rr_rsp2_result", rsp_result, 32'h0000_0007);
        check_eq("rr_gnt3", req_ready, 32'h2);
        tick(); req_valid = 2'b00;
        #1 check_eq("rr_rsp3_valid", rsp_valid, 32'h2);
        check_eq("rr_rsp3_result", rsp_result, 32'hF800_0000);

        // Backpressure on req1's response while req0 waits
        tick();
        req_valid = 2'b10; rsp_ready = 2'b01;
        #1 check_eq("bp_gnt1", req_ready, 32'h2);
        tick(); req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("bp_stall_ready", req_ready, 32'h0);
            check_eq("bp_stall_valid", rsp_valid, 32'h2);
            check_eq("bp_stall_result", rsp_result, 32'hF800_0000);
            tick();
        end
        rsp_ready = 2'b11;
        #1 check_eq("bp_release_ready", req_ready, 32'h1);
        check_eq("bp_release_valid", rsp_valid, 32'h2);
        tick(); req_valid = 2'b00;
        #1 check_eq("bp_next_valid", rsp_valid, 32'h1);
        check_eq("bp_next_result", rsp_result, 32'h0000_0007);

        // Flush with a pending response for req0 (pointer is 1)
        tick();
        req_valid = 2'b01; rsp_ready = 2'b00;
        #1 check_eq("fl_setup_ready", req_ready, 32'h1);
        tick(); req_valid = 2'b11; flush = 1'b1;
        #1 check_eq("fl_ready", req_ready, 32'h0);
        check_eq("fl_pending", rsp_valid, 32'h1);
        tick(); flush = 1'b0;
        #1 check_eq("fl_dropped", rsp_valid, 32'h0);
        check_eq("fl_idle", idle, 32'h1);
        check_eq("fl_ptr_held", req_ready, 32'h2);
        tick(); req_valid = 2'b00;
        #1 check_eq("fl_after_valid", rsp_valid, 32'h2);
        check_eq("fl_after_result", rsp_result, 32'hF800_0000);

        // Async reset while a response is stalled (pointer set to 1 first)
        rsp_ready = 2'b11;
        tick();
        req_valid = 2'b01;
        #1 check_eq("ar_setup_ready", req_ready, 32'h1);
        tick(); req_valid = 2'b00; rsp_ready = 2'b00;
        #1 check_eq("ar_pending", rsp_valid, 32'h1);
        tick();
        #1 check_eq("ar_stalled", rsp_valid, 32'h1);
        check_eq("ar_stalled_result", rsp_result, 32'h0000_0007);
        #1 rst_n = 1'b0;
        #1 check_eq("ar_valid_drop", rsp_valid, 32'h0);
        check_eq("ar_idle", idle, 32'h1);
        check_eq("ar_result_clr", rsp_result, 32'h0);
        #1 rst_n = 1'b1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1 check_eq("ar_ptr_reset", req_ready, 32'h1);
        tick(); req_valid = 2'b00;
        #1 check_eq("ar_post_valid", rsp_valid, 32'h1);
        check_eq("ar_post_result", rsp_result, 32'h0000_0007);

        // Undefined operation encoding yields zero
        tick();
        req_op[0] = alu_op_e'(4'hF); req_a[0] = 32'd5; req_b[0] = 32'd7;
        req_valid = 2'b01;
        #1 check_eq("undef_ready", req_ready, 32'h1);
        tick(); req_valid = 2'b00;
        #1 check_eq("undef_valid", rsp_valid, 32'h1);
        check_eq("undef_result", rsp_result, 32'h0);
        tick();
        #1 check_eq("final_idle", idle, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
